// File: rtl/fsm_persianas_multicanal.sv
// Multi-channel motorised-blind controller: per-channel mode/target FSM with
// reversal dead time, motion timeout, limit-conflict fault and a shared prescaler tick.
module fsm_persianas_multicanal #(
  parameter int N_CH    = 2,
  parameter int CH_W    = 1,
  parameter int PRESC_W = 25,
  parameter int T_MAX   = 20,
  parameter int T_DEAD  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          cmd,
  input  logic [CH_W-1:0]     cmd_ch,
  input  logic                cmd_all,
  input  logic                cmd_valid,
  input  logic [2*N_CH-1:0]   sensor,
  input  logic [N_CH-1:0]     s_sup,
  input  logic [N_CH-1:0]     s_med,
  input  logic [N_CH-1:0]     s_inf,
  output logic [N_CH-1:0]     subir,
  output logic [N_CH-1:0]     bajar,
  output logic [N_CH-1:0]     fault,
  output logic                tick
);

  localparam logic [2:0] MODO_NINGUNO = 3'd0;
  localparam logic [2:0] MODO_CERRAR  = 3'd1;
  localparam logic [2:0] MODO_MEDIO   = 3'd2;
  localparam logic [2:0] MODO_ABRIR   = 3'd3;
  localparam logic [2:0] MODO_AUTO    = 3'd4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SUBE  = 3'd1;
  localparam logic [2:0] ST_BAJA  = 3'd2;
  localparam logic [2:0] ST_PAUSA = 3'd3;
  localparam logic [2:0] ST_FALLA = 3'd4;

  // Shared encoding for targets and last known position; 0 means none/unknown.
  localparam logic [1:0] POS_NINGUNA  = 2'd0;
  localparam logic [1:0] POS_INFERIOR = 2'd1;
  localparam logic [1:0] POS_MEDIO    = 2'd2;
  localparam logic [1:0] POS_SUPERIOR = 2'd3;

  localparam logic [7:0] T_MAX_C  = 8'(T_MAX);
  localparam logic [7:0] T_DEAD_C = 8'(T_DEAD);

  logic [PRESC_W-1:0] presc;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the values present before the edge, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc <= '0;
    else       presc <= presc + PRESC_W'(1);
  end

  assign tick = &presc;

  logic       cmd_legal;
  logic [2:0] cmd_modo;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cmd_legal = 1'b1;
    cmd_modo  = MODO_NINGUNO;
    case (cmd)
      4'b0001: cmd_modo = MODO_CERRAR;
      4'b0010: cmd_modo = MODO_MEDIO;
      4'b0100: cmd_modo = MODO_ABRIR;
      4'b1000: cmd_modo = MODO_AUTO;
      default: cmd_legal = 1'b0;
    endcase
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_canal
    logic [2:0] modo;
    logic [2:0] estado;
    logic [2:0] estado_n;
    logic [1:0] objetivo;
    logic [1:0] objetivo_n;
    logic [1:0] ultima_pos;
    logic [1:0] luz;
    logic [7:0] t_mov;
    logic [7:0] t_mov_n;
    logic [7:0] t_muerto;
    logic [7:0] t_muerto_n;
    logic       dirigido;
    logic       alcanzado;
    logic       dir_subir;
    logic       conflicto;
    logic       subir_r;
    logic       bajar_r;
    logic       fault_r;

    assign luz       = sensor[2*i +: 2];
    assign conflicto = s_sup[i] & s_inf[i];
    assign dirigido  = cmd_valid && cmd_legal && (cmd_all || (cmd_ch == CH_W'(i)));

    always_ff @(posedge clk or posedge reset) begin
      if (reset)         modo <= MODO_NINGUNO;
      else if (dirigido) modo <= cmd_modo;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)         ultima_pos <= POS_NINGUNA;
      else if (s_sup[i]) ultima_pos <= POS_SUPERIOR;
      else if (s_med[i]) ultima_pos <= POS_MEDIO;
      else if (s_inf[i]) ultima_pos <= POS_INFERIOR;
    end

    // Light code 11 holds whatever target the channel had before.
    always_comb begin
      objetivo_n = objetivo;
      case (modo)
        MODO_CERRAR: objetivo_n = POS_INFERIOR;
        MODO_MEDIO:  objetivo_n = POS_MEDIO;
        MODO_ABRIR:  objetivo_n = POS_SUPERIOR;
        MODO_AUTO: begin
          case (luz)
            2'b00:   objetivo_n = POS_INFERIOR;
            2'b01:   objetivo_n = POS_MEDIO;
            2'b10:   objetivo_n = POS_SUPERIOR;
            default: objetivo_n = objetivo;
          endcase
        end
        default:     objetivo_n = POS_NINGUNA;
      endcase
    end

    always_comb begin
      alcanzado = 1'b1;
      dir_subir = 1'b0;
      case (objetivo_n)
        POS_INFERIOR: begin
          alcanzado = s_inf[i];
          dir_subir = 1'b0;
        end
        POS_MEDIO: begin
          alcanzado = s_med[i];
          if (s_sup[i] || ultima_pos == POS_SUPERIOR)      dir_subir = 1'b0;
          else if (s_inf[i] || ultima_pos == POS_INFERIOR) dir_subir = 1'b1;
          else                                             dir_subir = 1'b0;
        end
        POS_SUPERIOR: begin
          alcanzado = s_sup[i];
          dir_subir = 1'b1;
        end
        default: begin
          alcanzado = 1'b1;
          dir_subir = 1'b0;
        end
      endcase
    end

    // Fault clear is evaluated ahead of the tick so it wins over a coincident tick.
    always_comb begin
      estado_n   = estado;
      t_mov_n    = t_mov;
      t_muerto_n = t_muerto;
      if (estado == ST_FALLA && dirigido) begin
        estado_n   = ST_IDLE;
        t_mov_n    = '0;
        t_muerto_n = '0;
      end else if (tick) begin
        if (conflicto) begin
          estado_n = ST_FALLA;
        end else begin
          case (estado)
            ST_IDLE: begin
              if (!alcanzado) begin
                estado_n = dir_subir ? ST_SUBE : ST_BAJA;
                t_mov_n  = '0;
              end
            end
            ST_SUBE, ST_BAJA: begin
              if (alcanzado) begin
                estado_n = ST_IDLE;
              end else if (dir_subir != (estado == ST_SUBE)) begin
                estado_n   = ST_PAUSA;
                t_muerto_n = T_DEAD_C;
              end else begin
                t_mov_n = t_mov + 8'd1;
                if (t_mov_n == T_MAX_C) estado_n = ST_FALLA;
              end
            end
            ST_PAUSA: begin
              if (t_muerto <= 8'd1) begin
                estado_n   = ST_IDLE;
                t_muerto_n = '0;
              end else begin
                t_muerto_n = t_muerto - 8'd1;
              end
            end
            ST_FALLA: estado_n = ST_FALLA;
            default:  estado_n = ST_IDLE;
          endcase
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        estado   <= ST_IDLE;
        objetivo <= POS_NINGUNA;
        t_mov    <= '0;
        t_muerto <= '0;
        subir_r  <= 1'b0;
        bajar_r  <= 1'b0;
        fault_r  <= 1'b0;
      end else begin
        estado   <= estado_n;
        t_mov    <= t_mov_n;
        t_muerto <= t_muerto_n;
        if (tick) objetivo <= objetivo_n;
        subir_r  <= (estado_n == ST_SUBE);
        bajar_r  <= (estado_n == ST_BAJA);
        fault_r  <= (estado_n == ST_FALLA);
      end
    end

    assign subir[i] = subir_r;
    assign bajar[i] = bajar_r;
    assign fault[i] = fault_r;
  end

endmodule

// File: tb/tb_fsm_persianas_multicanal.sv
// Directed self-checking bench for fsm_persianas_multicanal (2 channels,
// 3-bit prescaler, timeout 6 ticks, dead time 2 ticks).
module tb_fsm_persianas_multicanal;

  localparam int N_CH    = 2;
  localparam int CH_W    = 1;
  localparam int PRESC_W = 3;
  localparam int T_MAX   = 6;
  localparam int T_DEAD  = 2;

  localparam logic [3:0] C_CERRAR = 4'b0001;
  localparam logic [3:0] C_MEDIO  = 4'b0010;
  localparam logic [3:0] C_ABRIR  = 4'b0100;
  localparam logic [3:0] C_AUTO   = 4'b1000;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        cmd;
  logic [CH_W-1:0]   cmd_ch;
  logic              cmd_all;
  logic              cmd_valid;
  logic [2*N_CH-1:0] sensor;
  logic [N_CH-1:0]   s_sup;
  logic [N_CH-1:0]   s_med;
  logic [N_CH-1:0]   s_inf;
  logic [N_CH-1:0]   subir;
  logic [N_CH-1:0]   bajar;
  logic [N_CH-1:0]   fault;
  logic              tick;

  int n_checks = 0;
  int n_fail   = 0;

  fsm_persianas_multicanal #(
    .N_CH(N_CH), .CH_W(CH_W), .PRESC_W(PRESC_W), .T_MAX(T_MAX), .T_DEAD(T_DEAD)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_ch(cmd_ch), .cmd_all(cmd_all),
    .cmd_valid(cmd_valid), .sensor(sensor), .s_sup(s_sup), .s_med(s_med),
    .s_inf(s_inf), .subir(subir), .bajar(bajar), .fault(fault), .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the next tick edge; a missing tick counts as a failure.
  task automatic esperar_tick();
    int k;
    k = 0;
    @(negedge clk);
    while (tick !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    assert (tick === 1'b1) else begin
      n_fail++;
      $error("FAIL tick_wait: observed %b expected 1", tick);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic comando(input logic [3:0] c, input logic [CH_W-1:0] ch, input logic all);
    cmd       = c;
    cmd_ch    = ch;
    cmd_all   = all;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_all   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd = '0; cmd_ch = '0; cmd_all = 1'b0; cmd_valid = 1'b0;
    sensor = '0; s_sup = '0; s_med = '0; s_inf = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_subir", subir, 2'b00);
    check("rst_bajar", bajar, 2'b00);
    check("rst_fault", fault, 2'b00);
    check("rst_tick", {1'b0, tick}, 2'b00);

    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      check("tick_cycle", {1'b0, tick}, (c == 7) ? 2'b01 : 2'b00);
    end
    esperar_tick();
    check("ninguno_subir", subir, 2'b00);
    check("ninguno_bajar", bajar, 2'b00);

    // ch0 opens from the bottom and stops at the top limit
    s_inf = 2'b01;
    comando(C_ABRIR, 1'b0, 1'b0);
    esperar_tick();
    check("abrir0_subir", subir, 2'b01);
    check("abrir0_bajar", bajar, 2'b00);
    s_inf = 2'b00; s_sup = 2'b01;
    esperar_tick();
    check("abrir0_stop", subir, 2'b00);
    esperar_tick();
    check("abrir0_idle", subir, 2'b00);

    // ch1 closes, then reverses through the dead time
    s_sup = 2'b11;
    comando(C_CERRAR, 1'b1, 1'b0);
    esperar_tick();
    check("cerrar1_bajar", bajar, 2'b10);
    check("cerrar1_subir", subir, 2'b00);
    s_sup = 2'b01;
    esperar_tick();
    check("cerrar1_sigue", bajar, 2'b10);
    comando(C_ABRIR, 1'b1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      esperar_tick();
      check("pausa1_bajar", bajar, 2'b00);
      check("pausa1_subir", subir, 2'b00);
    end
    esperar_tick();
    check("rev1_subir", subir, 2'b10);
    check("rev1_bajar", bajar, 2'b00);
    s_sup = 2'b11;
    esperar_tick();
    check("rev1_stop", subir, 2'b00);

    // ch0 timeout: no limit ever reached
    s_sup = 2'b10;
    for (int t = 0; t < 6; t++) begin
      esperar_tick();
      check("tout0_subir", subir, 2'b01);
      check("tout0_fault", fault, 2'b00);
    end
    esperar_tick();
    check("tout0_fault_on", fault, 2'b01);
    check("tout0_subir_off", subir, 2'b00);
    comando(C_MEDIO, 1'b0, 1'b0);
    check("clr0_fault", fault, 2'b00);
    check("clr0_subir", subir, 2'b00);
    esperar_tick();
    check("medio0_bajar", bajar, 2'b01);
    s_med = 2'b01;
    esperar_tick();
    check("medio0_stop", bajar, 2'b00);

    // ch1 auto: bright, hold, dark
    s_sup = 2'b00; s_inf = 2'b10; sensor = 4'b1000;
    comando(C_AUTO, 1'b1, 1'b0);
    esperar_tick();
    check("auto1_subir", subir, 2'b10);
    check("auto1_bajar", bajar, 2'b00);
    s_inf = 2'b00; sensor = 4'b1100;
    esperar_tick();
    check("auto1_hold", subir, 2'b10);
    sensor = 4'b0000;
    for (int p = 0; p < 3; p++) begin
      esperar_tick();
      check("auto1_pausa_s", subir, 2'b00);
      check("auto1_pausa_b", bajar, 2'b00);
    end
    esperar_tick();
    check("auto1_bajar_on", bajar, 2'b10);
    check("auto1_subir_off", subir, 2'b00);

    // broadcast close, then limit conflict on ch1
    comando(C_CERRAR, 1'b0, 1'b1);
    esperar_tick();
    check("bcast_bajar", bajar, 2'b11);
    check("bcast_subir", subir, 2'b00);
    s_sup = 2'b10; s_inf = 2'b10;
    esperar_tick();
    check("conf1_fault", fault, 2'b10);
    check("conf1_bajar", bajar, 2'b01);
    check("conf1_subir", subir, 2'b00);

    // asynchronous reset mid-motion, between clock edges
    #2;
    reset = 1'b1;
    #1;
    check("arst_bajar", bajar, 2'b00);
    check("arst_fault", fault, 2'b00);
    check("arst_subir", subir, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_persianas_multicanal.md
# fsm_persianas_multicanal

Next-generation motorised-blind controller: N_CH independent blind channels, each with its own close/half/open/auto mode, three limit sensors and a two-bit light sensor. Timing runs from one internal prescaler tick used as a clock enable; no derived clocks. Additions over the single-channel controller: reversal dead time, motion timeout with latched fault, sensor-conflict detection, and per-channel or broadcast commands. Sits between the switch/sensor inputs and the motor drivers at the top level.

## Interface
- N_CH, 2: number of blind channels (1..16).
- CH_W, 1: width of cmd_ch; 2**CH_W >= N_CH.
- PRESC_W, 25: prescaler width; one tick every 2**PRESC_W clk cycles.
- T_MAX, 20: motion timeout in ticks (1..255).
- T_DEAD, 2: reversal dead time in ticks (1..255).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd  in  4  one-hot command: 0001 cerrar, 0010 medio, 0100 abrir, 1000 auto; any other value ignored.
- cmd_ch  in  CH_W  target channel; values >= N_CH ignored unless cmd_all=1.
- cmd_all  in  1  broadcast command to every channel.
- cmd_valid  in  1  single-cycle command strobe.
- sensor  in  2*N_CH  light code per channel, bits [2i+1:2i]: 00 dark→cerrada, 01→media, 10 bright→abierta, 11 hold.
- s_sup, s_med, s_inf  in  N_CH each  upper/middle/lower limit switches, active-high.
- subir, bajar  out  N_CH each  motor up/down drive, registered.
- fault  out  N_CH  latched channel fault.
- tick  out  1  one-cycle prescaler pulse.

## Operation
- Prescaler: PRESC_W-bit counter, reset 0, free-running. tick=1 while count is all-ones.
- Mode register per channel: NINGUNO (reset), CERRAR, MEDIO, ABRIR, AUTO. Written on any clk edge with cmd_valid, a legal cmd, and channel addressed (cmd_ch==i or cmd_all).
- Target per channel, evaluated on tick: CERRAR→inferior; MEDIO→medio; ABRIR→superior; AUTO→from sensor code, with 11 keeping the previous target; NINGUNO→no target (stay IDLE).
- last_pos per channel: reset DESCONOCIDA. Each clk edge: s_inf→INFERIOR, s_med→MEDIO, s_sup→SUPERIOR (priority sup > med > inf).
- Target reached: inferior when s_inf, medio when s_med, superior when s_sup.
- Required direction when target not reached:
  - superior → up; inferior → down.
  - medio: down if s_sup or last_pos==SUPERIOR; up if s_inf or last_pos==INFERIOR; otherwise down.
- FSM per channel. States: IDLE, SUBE, BAJA, PAUSA, FALLA. Transitions occur only on tick, except the fault clear.
  - IDLE: target reached or none → stay. Otherwise → SUBE or BAJA; clear timeout counter.
  - SUBE/BAJA, target reached → IDLE.
  - SUBE/BAJA, required direction is the opposite → PAUSA; load dead counter with T_DEAD.
  - SUBE/BAJA, same direction → stay; timeout counter increments. At the tick where counter==T_MAX → FALLA.
  - PAUSA: dead counter decrements each tick. At 0 → IDLE, then re-evaluate on the next tick.
  - Any state: s_sup and s_inf both 1 at a tick → FALLA (highest priority).
  - FALLA: outputs off, fault=1. A command addressed to the channel (cmd_valid with a legal cmd) → IDLE at that clk edge, fault=0, counters cleared; this wins over a coincident tick.
- Outputs: subir=1 only in SUBE, bajar=1 only in BAJA. subir and bajar are never 1 together. Neither is 1 in PAUSA, IDLE or FALLA.

## Timing
- Reset values: subir=0, bajar=0, fault=0, tick=0, state IDLE, mode NINGUNO, counters 0, last_pos DESCONOCIDA.
- Reset is asynchronous. Asserting it mid-motion drops subir/bajar immediately.
- A command takes effect at the first tick strictly after the edge that captured it. A command coincident with a tick is used at the following tick.
- Motion output changes on the clk edge where tick=1; latency from the tick edge is 0 cycles (registered at that edge).
- Reversal: minimum T_DEAD+1 ticks with both outputs 0 between opposite drives.
- Channels are independent; a broadcast updates all channels on the same edge.

## Test plan
Configuration: N_CH=2, PRESC_W=3, T_MAX=6, T_DEAD=2.
- Reset release: tick pulses at cycles 7, 15, 23…; all outputs 0; no motion with mode NINGUNO.
- ch0 ABRIR with s_inf=1 → subir[0]=1 from the next tick. Raise s_sup[0] → subir[0]=0 at the following tick, state IDLE.
- ch1 moving down under CERRAR, then issue ABRIR → bajar[1]=0 for 3 ticks, then subir[1]=1; never both high.
- ch0 ABRIR with no limit ever reached → subir[0] high for 6 ticks, then fault[0]=1, subir[0]=0. A MEDIO command clears fault[0] on the next edge.
- ch1 AUTO, sensor[3:2] sequence 10→11→00 → drives up; holds target on 11; reverses via PAUSA on 00. Ch0 unaffected.
- Broadcast CERRAR with cmd_all=1 → bajar=2'b11 at the next tick. s_sup[1]=s_inf[1]=1 → fault[1]=1 at the next tick, ch0 keeps bajar[0].
